// File: rtl/seq_serializer.sv
// seq_serializer: parallel-to-serial converter with one-word holding register and zero-gap streaming
module seq_serializer #(
  parameter int   WIDTH     = 8,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             shift_en,
  output logic             dout,
  output logic             dout_valid,
  output logic             dout_last,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] hr, sr, sr_n;
  logic [CW-1:0]    cnt, cnt_n, idx;
  logic             hr_full, hr_full_n, acc, xfer, at_last;
  logic             dout_n, dout_valid_n, dout_last_n, busy_n;
  assign in_ready = rst_n && !hr_full;
  assign acc      = in_valid && in_ready;
  assign at_last  = cnt == LAST;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      hr_full    <= 1'b0;
      hr         <= '0;
      sr         <= '0;
      cnt        <= '0;
      dout       <= IDLE_BIT;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      hr_full    <= hr_full_n;
      sr         <= sr_n;
      cnt        <= cnt_n;
      dout       <= dout_n;
      dout_valid <= dout_valid_n;
      dout_last  <= dout_last_n;
      busy       <= busy_n;
      if (acc) hr <= in_data;
    end
  end
  always_comb begin
    xfer      = shift_en && hr_full && (state == IDLE || at_last);
    state_n   = xfer ? SHIFT : (shift_en && state == SHIFT && at_last) ? IDLE : state;
    cnt_n     = xfer ? '0 : (!shift_en || state == IDLE) ? cnt : at_last ? '0 : cnt + CW'(1);
    sr_n      = xfer ? hr : sr;
    hr_full_n = acc ? 1'b1 : xfer ? 1'b0 : hr_full;
  end
  // Outputs are computed from next-state values so they register in step with the state.
  always_comb begin
    idx          = (MSB_FIRST != 0) ? LAST - cnt_n : cnt_n;
    dout_valid_n = state_n == SHIFT;
    dout_n       = dout_valid_n ? sr_n[idx] : IDLE_BIT;
    dout_last_n  = dout_valid_n && cnt_n == LAST;
    busy_n       = dout_valid_n || hr_full_n;
  end
endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
- Parallel-to-serial converter that feeds the serial sequence-detector stage one bit per clock.
- Accepts WIDTH-bit words over a valid/ready handshake and holds one word in a holding register.
- Shifts each word out on dout with a bit-valid qualifier and a last-bit marker.
- Back-to-back words stream with no idle bit between them.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = in_data[WIDTH-1] is sent first; 0 = in_data[0] is sent first.
- IDLE_BIT, 1'b0, value driven on dout whenever dout_valid=0.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_data  input  WIDTH  parallel word; sampled when in_valid && in_ready.
- in_valid  input  1  source has a word.
- in_ready  output  1  holding register can accept a word.
- shift_en  input  1  advance enable; 0 freezes the serial side.
- dout  output  1  serial bit to the detector's din.
- dout_valid  output  1  dout carries a payload bit.
- dout_last  output  1  dout is the final bit of the current word.
- busy  output  1  a word is held or being shifted.

Behaviour:
- Reset: reset is synchronous, active-low on rst_n; clock is clk. The reset edge gives state IDLE, hr_full=0, bit counter 0, dout=IDLE_BIT, dout_valid=0, dout_last=0, busy=0. in_ready is gated to 0 combinationally while rst_n=0.
- Reset mid-word: all in-flight and held data is discarded. No partial word resumes after reset.
- Handshake:
  - in_ready = rst_n && !hr_full. This depends only on registers, with no combinational path from shift_en or in_valid.
  - A word is accepted at an edge where in_valid && in_ready. It enters the holding register (HR) and hr_full goes to 1.
  - The source must hold in_data stable while in_valid=1 && in_ready=0. There is no loss and no duplication.
- Transfer HR->SR happens at an edge where shift_en=1 && hr_full=1 and either:
  - state is IDLE, or
  - state is SHIFT and the displayed bit is the last one (cnt==WIDTH-1).
  On transfer: SR<=HR, cnt<=0, hr_full<=0, state<=SHIFT. HR can be refilled at the next acceptance edge (in_ready is high in the cycle after transfer).
- Latency: the word accepted at edge E0 drives its first bit, with dout_valid=1, in the cycle after edge E0+1, provided shift_en=1.
- State machine, 2 states:
  - IDLE: dout=IDLE_BIT, dout_valid=0. Goes to SHIFT on a transfer.
  - SHIFT: dout = current bit of SR (order set by MSB_FIRST), dout_valid=1, dout_last=(cnt==WIDTH-1).
  - At an edge with shift_en=1 and cnt<WIDTH-1: cnt++, and the next bit is displayed.
  - At an edge with shift_en=1 and cnt==WIDTH-1: if hr_full, transfer (zero-gap streaming); otherwise go to IDLE.
- shift_en=0: SR, cnt, state, dout, dout_valid and dout_last all hold. Each bit stays displayed until an edge with shift_en=1. HR acceptance continues; transfer is deferred.
- Simultaneous transfer and acceptance at the same edge is impossible, because in_ready=0 whenever hr_full=1.
- busy = (state==SHIFT) || hr_full.
- All outputs except in_ready are registered.
- Counter width is clog2(WIDTH). cnt never exceeds WIDTH-1.

Test Plan:
- Single word, WIDTH=8, MSB_FIRST=1, shift_en=1, in_data=8'hB2 accepted at edge 0 -> cycles after edges 1..8: dout=1,0,1,1,0,0,1,0 with dout_valid=1. dout_last=1 only on the 8th bit. After edge 9: dout_valid=0, dout=0, busy=0.
- Back-to-back: in_valid held with words 8'hA5 then 8'h3C -> 16 consecutive dout_valid cycles with no gap: 10100101 00111100. in_ready=0 while HR holds 8'h3C. No word is lost or duplicated.
- Stall: word 8'hF0, shift_en=0 for 3 cycles after the 2nd bit -> the 2nd bit (1) is held for 4 cycles. The remaining 6 bits follow. Total 8 distinct bits, dout_last on the final 0.
- Reset mid-word: rst_n=0 after 3 bits with HR full -> after that edge: dout_valid=0, dout=IDLE_BIT, dout_last=0, busy=0. in_ready=0 while rst_n=0, and 1 on the first cycle after release. No residual bits appear.
- LSB-first: MSB_FIRST=0, in_data=8'h0B -> dout=1,1,0,1,0,0,0,0.
- End-to-end with the detector: serial stream from words 8'h0B, 8'h4D fed to the detector's din -> detector flag pulses align with the bit positions computed from the known bit order. No spurious bits are seen during IDLE cycles.
